// File: rtl/pattern_detector_pkg.sv
// Shared defaults and the pattern-length width helper for the serial pattern detector.
package pattern_detector_pkg;

    localparam int DEFAULT_MAX_LEN = 8;
    localparam int DEFAULT_CNT_W   = 8;

    // Len must encode 0..MAX_LEN inclusive, so one more value than MAX_LEN.
    function automatic int len_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/pattern_detector_if.sv
// Configuration, data and result bundle of the pattern detector; clock and reset stay plain ports.
interface pattern_detector_if
    import pattern_detector_pkg::*;
#(
    parameter int MAX_LEN = DEFAULT_MAX_LEN,
    parameter int CNT_W   = DEFAULT_CNT_W
) ();

    localparam int LEN_W = len_width(MAX_LEN);

    logic               Clear;
    logic               En;
    logic               X;
    logic [MAX_LEN-1:0] Pattern;
    logic [LEN_W-1:0]   Len;
    logic               Overlap;
    logic               Y;
    logic [CNT_W-1:0]   Count;
    logic               Sat;

    modport master (
        output Clear, En, X, Pattern, Len, Overlap,
        input  Y, Count, Sat
    );

    modport slave (
        input  Clear, En, X, Pattern, Len, Overlap,
        output Y, Count, Sat
    );

endinterface

// File: rtl/pattern_detector_bit_history.sv
// Enable-gated history shift register plus saturating fill counter; exposes the next-state
// values so the caller can compare against the bit being shifted in this cycle.
module bit_history
    import pattern_detector_pkg::*;
#(
    parameter int  MAX_LEN = DEFAULT_MAX_LEN,
    localparam int LEN_W   = len_width(MAX_LEN)
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               Clear,
    input  logic               En,
    input  logic               X,
    input  logic               fill_clear,
    output logic [MAX_LEN-1:0] hist_next,
    output logic [LEN_W-1:0]   fill_next
);

    localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] hist_reg;
    logic [LEN_W-1:0]   fill_reg;

    // Newest bit lands in position 0; the oldest falls off the top.
    assign hist_next = (hist_reg << 1) | MAX_LEN'(X);
    assign fill_next = (fill_reg == FILL_MAX) ? fill_reg : fill_reg + 1'b1;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            hist_reg <= '0;
            fill_reg <= '0;
        end else if (Clear) begin
            hist_reg <= '0;
            fill_reg <= '0;
        end else if (En) begin
            // A non-overlapping match restarts the fill but keeps the history bits.
            hist_reg <= hist_next;
            fill_reg <= fill_clear ? '0 : fill_next;
        end
    end

endmodule

// File: rtl/pattern_detector.sv
// Runtime-programmable serial pattern detector: masked compare on the incoming history,
// registered match pulse and a saturating match counter with a sticky saturation flag.
module pattern_detector
    import pattern_detector_pkg::*;
#(
    parameter int MAX_LEN = DEFAULT_MAX_LEN,
    parameter int CNT_W   = DEFAULT_CNT_W
) (
    input  logic               Clk,
    input  logic               Rst_n,
    pattern_detector_if.slave  bus
);

    localparam int               LEN_W   = len_width(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    logic [MAX_LEN-1:0] hist_next;
    logic [MAX_LEN-1:0] len_mask;
    logic [LEN_W-1:0]   fill_next;
    logic               len_ok;
    logic               match;
    logic               y_reg;
    logic               sat_reg;
    logic [CNT_W-1:0]   count_reg;

    bit_history #(
        .MAX_LEN (MAX_LEN)
    ) u_hist (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .Clear      (bus.Clear),
        .En         (bus.En),
        .X          (bus.X),
        .fill_clear (match && !bus.Overlap),
        .hist_next  (hist_next),
        .fill_next  (fill_next)
    );

    // Only the Len youngest history bits take part in the compare.
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
        assign len_mask[gi] = (bus.Len > LEN_W'(gi));
    end

    assign len_ok = (bus.Len != '0) && (bus.Len <= LEN_MAX);
    assign match  = len_ok && (fill_next >= bus.Len)
                  && (((hist_next ^ bus.Pattern) & len_mask) == '0);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            y_reg     <= 1'b0;
            count_reg <= '0;
            sat_reg   <= 1'b0;
        end else if (bus.Clear) begin
            y_reg     <= 1'b0;
            count_reg <= '0;
            sat_reg   <= 1'b0;
        end else if (bus.En) begin
            y_reg <= match;
            if (match) begin
                if (count_reg == '1) begin
                    sat_reg <= 1'b1;
                end else begin
                    count_reg <= count_reg + 1'b1;
                end
            end
        end else begin
            y_reg <= 1'b0;
        end
    end

    assign bus.Y     = y_reg;
    assign bus.Count = count_reg;
    assign bus.Sat   = sat_reg;

endmodule

// File: tb/tb_pattern_detector.sv
// Self-checking bench: a directed vector table, hand-written corner sequences, and randomized
// traffic compared against a queue-based reference model; two instances cover CNT_W=8 and CNT_W=4.
module tb_pattern_detector;

    logic Clk;
    logic Rst_n;

    pattern_detector_if #(.MAX_LEN(8), .CNT_W(8)) bus8 ();
    pattern_detector_if #(.MAX_LEN(8), .CNT_W(4)) bus4 ();

    pattern_detector #(.MAX_LEN(8), .CNT_W(8)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus8)
    );

    pattern_detector #(.MAX_LEN(8), .CNT_W(4)) dut_sat (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus4)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: bits consumed since the last flush (reset, Clear, or non-overlapping match).
    bit fresh[$];
    int m_matches;
    bit m_y;

    typedef struct {
        logic       clr;
        logic       en;
        logic       x;
        logic [7:0] pat;
        logic [3:0] len;
        logic       ovl;
        logic       y;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[$];

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        fresh.delete();
        m_matches = 0;
        m_y       = 1'b0;
    endtask

    task automatic model_step(input logic clr, input logic en, input logic x,
                              input logic [7:0] pat, input logic [3:0] len, input logic ovl);
        bit hit;
        if (clr) begin
            model_reset();
        end else if (en) begin
            fresh.push_back(x);
            if (fresh.size() > 8) void'(fresh.pop_front());
            hit = (len >= 1) && (len <= 8) && (fresh.size() >= int'(len));
            if (hit) begin
                for (int i = 0; i < int'(len); i++) begin
                    if (fresh[fresh.size() - 1 - i] != pat[i]) hit = 1'b0;
                end
            end
            m_y = hit;
            if (hit) begin
                m_matches++;
                if (!ovl) fresh.delete();
            end
        end else begin
            m_y = 1'b0;
        end
    endtask

    function automatic int exp_cnt(input int max_cnt);
        return (m_matches > max_cnt) ? max_cnt : m_matches;
    endfunction

    task automatic drive(input logic clr, input logic en, input logic x,
                         input logic [7:0] pat, input logic [3:0] len, input logic ovl);
        bus8.Clear = clr; bus8.En = en; bus8.X = x;
        bus8.Pattern = pat; bus8.Len = len; bus8.Overlap = ovl;
        bus4.Clear = clr; bus4.En = en; bus4.X = x;
        bus4.Pattern = pat; bus4.Len = len; bus4.Overlap = ovl;
        @(posedge Clk);
        model_step(clr, en, x, pat, len, ovl);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_y8"},   32'(bus8.Y),     32'(m_y));
        check({tag, "_cnt8"}, 32'(bus8.Count), exp_cnt(255));
        check({tag, "_sat8"}, 32'(bus8.Sat),   32'(m_matches > 255));
        check({tag, "_y4"},   32'(bus4.Y),     32'(m_y));
        check({tag, "_cnt4"}, 32'(bus4.Count), exp_cnt(15));
        check({tag, "_sat4"}, 32'(bus4.Sat),   32'(m_matches > 15));
    endtask

    task automatic add(input logic clr, input logic en, input logic x, input logic [7:0] pat,
                       input logic [3:0] len, input logic ovl, input logic y, input logic [7:0] cnt);
        vec_t v;
        v.clr = clr; v.en = en; v.x = x; v.pat = pat;
        v.len = len; v.ovl = ovl; v.y = y; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    initial begin
        logic [7:0] r_pat;
        logic [3:0] r_len;
        logic       r_ovl;
        logic       r_clr;
        logic       r_en;
        logic       r_x;
        int         base;

        // Pattern 100, overlap: matches after bits 3 and 6
        add(1, 0, 0, 8'h04, 4'd3, 1, 0, 0);
        add(0, 1, 1, 8'h04, 4'd3, 1, 0, 0);
        add(0, 1, 0, 8'h04, 4'd3, 1, 0, 0);
        add(0, 1, 0, 8'h04, 4'd3, 1, 1, 1);
        add(0, 1, 1, 8'h04, 4'd3, 1, 0, 1);
        add(0, 1, 0, 8'h04, 4'd3, 1, 0, 1);
        add(0, 1, 0, 8'h04, 4'd3, 1, 1, 2);
        // Pattern 111, six ones, overlapping
        add(1, 0, 0, 8'h07, 4'd3, 1, 0, 0);
        add(0, 1, 1, 8'h07, 4'd3, 1, 0, 0);
        add(0, 1, 1, 8'h07, 4'd3, 1, 0, 0);
        add(0, 1, 1, 8'h07, 4'd3, 1, 1, 1);
        add(0, 1, 1, 8'h07, 4'd3, 1, 1, 2);
        add(0, 1, 1, 8'h07, 4'd3, 1, 1, 3);
        add(0, 1, 1, 8'h07, 4'd3, 1, 1, 4);
        // Pattern 111, six ones, non-overlapping
        add(1, 0, 0, 8'h07, 4'd3, 0, 0, 0);
        add(0, 1, 1, 8'h07, 4'd3, 0, 0, 0);
        add(0, 1, 1, 8'h07, 4'd3, 0, 0, 0);
        add(0, 1, 1, 8'h07, 4'd3, 0, 1, 1);
        add(0, 1, 1, 8'h07, 4'd3, 0, 0, 1);
        add(0, 1, 1, 8'h07, 4'd3, 0, 0, 1);
        add(0, 1, 1, 8'h07, 4'd3, 0, 1, 2);
        // Pattern 100 across an En=0 gap
        add(1, 0, 0, 8'h04, 4'd3, 1, 0, 0);
        add(0, 1, 1, 8'h04, 4'd3, 1, 0, 0);
        add(0, 0, 0, 8'h04, 4'd3, 1, 0, 0);
        add(0, 0, 0, 8'h04, 4'd3, 1, 0, 0);
        add(0, 0, 0, 8'h04, 4'd3, 1, 0, 0);
        add(0, 0, 0, 8'h04, 4'd3, 1, 0, 0);
        add(0, 1, 0, 8'h04, 4'd3, 1, 0, 0);
        add(0, 1, 0, 8'h04, 4'd3, 1, 1, 1);
        // Clear has priority over En and discards X
        add(1, 0, 0, 8'h03, 4'd2, 1, 0, 0);
        add(0, 1, 1, 8'h03, 4'd2, 1, 0, 0);
        add(0, 1, 1, 8'h03, 4'd2, 1, 1, 1);
        add(1, 1, 1, 8'h03, 4'd2, 1, 0, 0);
        add(0, 1, 1, 8'h03, 4'd2, 1, 0, 0);
        add(0, 1, 1, 8'h03, 4'd2, 1, 1, 1);
        // Len=0 never matches
        add(1, 0, 0, 8'h01, 4'd0, 1, 0, 0);
        add(0, 1, 1, 8'h01, 4'd0, 1, 0, 0);
        add(0, 1, 1, 8'h01, 4'd0, 1, 0, 0);

        Rst_n = 1'b0;
        bus8.Clear = 0; bus8.En = 0; bus8.X = 0; bus8.Pattern = '0; bus8.Len = '0; bus8.Overlap = 0;
        bus4.Clear = 0; bus4.En = 0; bus4.X = 0; bus4.Pattern = '0; bus4.Len = '0; bus4.Overlap = 0;
        model_reset();

        @(posedge Clk);
        #1;
        check("rst_y",     32'(bus8.Y),     0);
        check("rst_count", 32'(bus8.Count), 0);
        check("rst_sat",   32'(bus8.Sat),   0);
        #2 Rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].clr, vecs[i].en, vecs[i].x, vecs[i].pat, vecs[i].len, vecs[i].ovl);
            $display("vec %0d clr=%0b en=%0b x=%0b y=%0b count=%0d", i,
                     vecs[i].clr, vecs[i].en, vecs[i].x, bus8.Y, bus8.Count);
            check($sformatf("vec%0d_y", i),   32'(bus8.Y),     32'(vecs[i].y));
            check($sformatf("vec%0d_cnt", i), 32'(bus8.Count), 32'(vecs[i].cnt));
            check($sformatf("vec%0d_y4", i),  32'(bus4.Y),     32'(vecs[i].y));
            check($sformatf("vec%0d_sat", i), 32'(bus8.Sat),   0);
        end

        // Saturation of the 4-bit counter, then Clear
        drive(1, 0, 0, 8'h01, 4'd1, 1);
        for (int i = 1; i <= 20; i++) begin
            drive(0, 1, 1, 8'h01, 4'd1, 1);
            $display("sat %0d y=%0b count4=%0d sat4=%0b", i, bus4.Y, bus4.Count, bus4.Sat);
            check($sformatf("sat%0d_y4", i),    32'(bus4.Y),     1);
            check($sformatf("sat%0d_cnt4", i),  32'(bus4.Count), (i > 15) ? 15 : i);
            check($sformatf("sat%0d_flag4", i), 32'(bus4.Sat),   32'(i >= 16));
            check($sformatf("sat%0d_cnt8", i),  32'(bus8.Count), i);
        end
        drive(1, 1, 1, 8'h01, 4'd1, 1);
        $display("sat clear y=%0b count4=%0d sat4=%0b", bus4.Y, bus4.Count, bus4.Sat);
        check("satclr_cnt4", 32'(bus4.Count), 0);
        check("satclr_sat4", 32'(bus4.Sat),   0);
        check("satclr_y4",   32'(bus4.Y),     0);

        // Asynchronous reset mid-cycle while Y is high, then fill must restart from zero
        drive(1, 0, 0, 8'h04, 4'd3, 1);
        drive(0, 1, 1, 8'h04, 4'd3, 1);
        drive(0, 1, 0, 8'h04, 4'd3, 1);
        drive(0, 1, 0, 8'h04, 4'd3, 1);
        check("pre_rst_y", 32'(bus8.Y), 1);
        #2 Rst_n = 1'b0;
        #1;
        $display("async reset y=%0b count=%0d sat=%0b", bus8.Y, bus8.Count, bus8.Sat);
        check("arst_y",    32'(bus8.Y),     0);
        check("arst_cnt",  32'(bus8.Count), 0);
        check("arst_sat",  32'(bus8.Sat),   0);
        check("arst_cnt4", 32'(bus4.Count), 0);
        model_reset();
        #1 Rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            drive(0, 1, 0, 8'h00, 4'd3, 1);
            $display("post reset bit %0d y=%0b count=%0d", i, bus8.Y, bus8.Count);
            check($sformatf("postrst%0d_y", i), 32'(bus8.Y), 32'(i == 3));
        end

        // Out-of-range lengths: nothing matches, count frozen
        base = exp_cnt(255);
        for (int i = 0; i < 100; i++) begin
            r_x = 1'($urandom);
            drive(0, 1, r_x, 8'($urandom), (i < 50) ? 4'd0 : 4'd9, 1'($urandom));
            $display("badlen %0d x=%0b y=%0b count=%0d", i, r_x, bus8.Y, bus8.Count);
            check("badlen_y",   32'(bus8.Y),     0);
            check("badlen_cnt", 32'(bus8.Count), base);
        end

        // Randomized traffic against the reference model
        r_pat = 8'($urandom);
        r_len = 4'($urandom_range(1, 4));
        r_ovl = 1'($urandom);
        for (int i = 0; i < 400; i++) begin
            if (i % 25 == 0) begin
                r_pat = 8'($urandom);
                r_len = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 9))
                                                    : 4'($urandom_range(1, 4));
                r_ovl = 1'($urandom);
            end
            r_clr = ($urandom_range(0, 31) == 0);
            r_en  = ($urandom_range(0, 3) != 0);
            r_x   = 1'($urandom);
            drive(r_clr, r_en, r_x, r_pat, r_len, r_ovl);
            $display("rnd %0d clr=%0b en=%0b x=%0b len=%0d ovl=%0b y=%0b count=%0d",
                     i, r_clr, r_en, r_x, r_len, r_ovl, bus8.Y, bus8.Count);
            check_model("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
